// File: rtl/idss_feeder_if.sv
// External memory read port of the idss feeder: address/enable out, data back one cycle later.
interface idss_feeder_if #(
    parameter int ADDR_WIDTH    = 20,
    parameter int IO_DATA_WIDTH = 16
);
    logic                     mem_re;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [IO_DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_re, output mem_addr, input mem_rdata);
    modport slave  (input mem_re, input mem_addr, output mem_rdata);
endinterface

// File: rtl/idss_feeder.sv
// Fetches a 3-row pixel band column by column from memory and feeds the input data shift system,
// steering each column to a stage via LE_select and pulsing shift once per group of four columns.
module idss_feeder #(
    parameter int IO_DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH        = 20,
    parameter int FEATURE_MAP_WIDTH = 1024,
    parameter int COL_WIDTH         = 11
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [ADDR_WIDTH-1:0]    row_idx,
    input  logic [COL_WIDTH-1:0]     num_cols,
    input  logic                     stall,
    idss_feeder_if.master            mem,
    output logic [IO_DATA_WIDTH-1:0] row_1,
    output logic [IO_DATA_WIDTH-1:0] row_2,
    output logic [IO_DATA_WIDTH-1:0] row_3,
    output logic [1:0]               LE_select,
    output logic                     shift,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_WIDTH-1:0] Pitch = ADDR_WIDTH'(FEATURE_MAP_WIDTH);

    typedef enum logic [2:0] {StIdle, StRd, StWb, StLoad, StShift, StFin} state_e;

    state_e                   state_q, state_d;
    logic [COL_WIDTH-1:0]     c_q, c_d;
    logic [1:0]               k_q, k_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [ADDR_WIDTH-1:0]    row_q, row_d;
    logic [COL_WIDTH-1:0]     num_q, num_d;
    logic [IO_DATA_WIDTH-1:0] stage_q [3];
    logic                     re_q;
    logic [1:0]               rk_q;
    logic [IO_DATA_WIDTH-1:0] row1_q, row2_q, row3_q;
    logic [1:0]               le_q;

    logic                     rd_issue;
    logic                     load_en;
    logic                     last_col;
    logic [ADDR_WIDTH-1:0]    row_sum;
    logic [ADDR_WIDTH-1:0]    rd_addr;

    assign last_col = (c_q == num_q - COL_WIDTH'(1));
    assign row_sum  = row_q + ADDR_WIDTH'(k_q);
    // Wraps modulo 2^ADDR_WIDTH by construction; no bounds check on rows or columns.
    assign rd_addr  = base_q + row_sum * Pitch + ADDR_WIDTH'(c_q);

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        k_d      = k_q;
        base_d   = base_q;
        row_d    = row_q;
        num_d    = num_q;
        rd_issue = 1'b0;
        load_en  = 1'b0;
        shift    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    row_d   = row_idx;
                    num_d   = num_cols;
                    c_d     = '0;
                    k_d     = '0;
                    state_d = (num_cols == '0) ? StFin : StRd;
                end
            end
            StRd: begin
                if (!stall) begin
                    rd_issue = 1'b1;
                    if (k_q == 2'd2) begin
                        state_d = StWb;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            StWb: state_d = StLoad;
            StLoad: begin
                load_en = 1'b1;
                if (c_q[1:0] == 2'd3 || last_col) begin
                    state_d = StShift;
                end else begin
                    c_d     = c_q + COL_WIDTH'(1);
                    k_d     = '0;
                    state_d = StRd;
                end
            end
            StShift: begin
                if (!stall) begin
                    shift = 1'b1;
                    if (last_col) begin
                        state_d = StFin;
                    end else begin
                        c_d     = c_q + COL_WIDTH'(1);
                        k_d     = '0;
                        state_d = StRd;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q <= StIdle;
            c_q     <= '0;
            k_q     <= '0;
            base_q  <= '0;
            row_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
            base_q  <= base_d;
            row_q   <= row_d;
            num_q   <= num_d;
        end
    end

    // Read data lands one cycle after issue; remember which stage slot it belongs to.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            re_q <= 1'b0;
            rk_q <= '0;
            for (int i = 0; i < 3; i++) stage_q[i] <= '0;
        end else begin
            re_q <= rd_issue;
            rk_q <= k_q;
            if (re_q) stage_q[rk_q] <= mem.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            row1_q <= '0;
            row2_q <= '0;
            row3_q <= '0;
            le_q   <= '0;
        end else if (load_en) begin
            row1_q <= stage_q[0];
            row2_q <= stage_q[1];
            row3_q <= stage_q[2];
            le_q   <= c_q[1:0];
        end
    end

    assign mem.mem_re   = rd_issue;
    assign mem.mem_addr = (state_q == StRd) ? rd_addr : '0;
    assign row_1        = row1_q;
    assign row_2        = row2_q;
    assign row_3        = row3_q;
    assign LE_select    = le_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StFin);

endmodule

// File: tb/tb_idss_feeder.sv
// Directed bench for idss_feeder: memory returns mem[a] = a, per-scenario tasks check addresses,
// loaded rows, shift/done cycles and reset behaviour against hand-derived values.
module tb_idss_feeder;

    logic        clk = 1'b0;
    logic        arst_n_in = 1'b0;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [19:0] row_idx = '0;
    logic [10:0] num_cols = '0;
    logic        stall = 1'b0;
    logic [15:0] row_1, row_2, row_3;
    logic [1:0]  LE_select;
    logic        shift, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    idss_feeder_if mif ();

    idss_feeder dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .start     (start),
        .base_addr (base_addr),
        .row_idx   (row_idx),
        .num_cols  (num_cols),
        .stall     (stall),
        .mem       (mif.master),
        .row_1     (row_1),
        .row_2     (row_2),
        .row_3     (row_3),
        .LE_select (LE_select),
        .shift     (shift),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, mem[a] = a truncated to the pixel width.
    always @(posedge clk) if (mif.mem_re) mif.mem_rdata <= mif.mem_addr[15:0];

    // Observations of one band, cycle 0 being the cycle start is high.
    logic [19:0] addr_q [$];
    int          shift_q [$];
    logic [15:0] obs_r1 [16], obs_r2 [16], obs_r3 [16];
    logic [1:0]  obs_le [16];
    int          obs_seen, done_cy, done_cnt, first_re_cy, re_in_stall;
    logic        busy1, busy_post;

    task automatic run_band(input logic [19:0] base, input logic [19:0] row, input logic [10:0] n,
                            input int sa, input int sb, input int s2a, input int s2b,
                            input int rs_cy);
        int reads;
        int chk_q [$];
        addr_q.delete();
        shift_q.delete();
        obs_seen = 0; done_cy = -1; done_cnt = 0; first_re_cy = -1; re_in_stall = 0;
        busy1 = 1'b0; busy_post = 1'b1; reads = 0;
        @(posedge clk); #1;
        base_addr = base; row_idx = row; num_cols = n; start = 1'b1;
        for (int cy = 1; cy <= 300; cy++) begin
            @(posedge clk); #1;
            start = (cy == rs_cy);
            if (cy == rs_cy) begin
                base_addr = 20'd500; row_idx = 20'd9; num_cols = 11'd0;
            end
            stall = (cy >= sa && cy <= sb) || (cy >= s2a && cy <= s2b);
            #1;
            if (cy == 1) busy1 = busy;
            // Rows become visible three cycles after the third read of a column (WB, LOAD, next).
            if (chk_q.size() > 0 && chk_q[0] == cy) begin
                if (obs_seen < 16) begin
                    obs_r1[obs_seen] = row_1; obs_r2[obs_seen] = row_2;
                    obs_r3[obs_seen] = row_3; obs_le[obs_seen] = LE_select;
                end
                obs_seen++;
                void'(chk_q.pop_front());
            end
            if (mif.mem_re) begin
                if (first_re_cy < 0) first_re_cy = cy;
                addr_q.push_back(mif.mem_addr);
                if (stall) re_in_stall++;
                reads++;
                if (reads % 3 == 0) chk_q.push_back(cy + 3);
            end
            if (shift) shift_q.push_back(cy);
            if (done) begin
                done_cnt++;
                if (done_cy < 0) done_cy = cy;
            end
            if (done_cy >= 0 && cy == done_cy + 1) begin
                busy_post = busy;
                break;
            end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({mif.mem_re, mif.mem_addr, row_1, row_2, row_3, LE_select, shift, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got re=%b addr=%h r=%h/%h/%h le=%0d sh=%b busy=%b done=%b, want all 0",
                     mif.mem_re, mif.mem_addr, row_1, row_2, row_3, LE_select, shift, busy, done);
        end
        @(posedge clk); #1;
        arst_n_in = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_group();
        logic [19:0] ea;
        logic [19:0] ga;
        run_band(20'd0, 20'd0, 11'd4, -1, -1, -1, -1, -1);
        n_cmp++;
        if (first_re_cy !== 1 || busy1 !== 1'b1) begin
            n_bad++; $display("FAIL single_first_re: got cy=%0d busy=%b want cy=1 busy=1", first_re_cy, busy1);
        end
        n_cmp++;
        if (addr_q.size() !== 12) begin
            n_bad++; $display("FAIL single_nreads: got %0d want 12", addr_q.size());
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) begin
                ea = 20'(c + k * 1024);
                ga = (c * 3 + k < addr_q.size()) ? addr_q[c * 3 + k] : 20'hxxxxx;
                n_cmp++;
                if (ga !== ea) begin
                    n_bad++; $display("FAIL single_addr c%0d k%0d: got %h want %h", c, k, ga, ea);
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if ({obs_r1[j], obs_r2[j], obs_r3[j], obs_le[j]} !==
                {16'(j), 16'(1024 + j), 16'(2048 + j), 2'(j)}) begin
                n_bad++;
                $display("FAIL single_load col%0d: got %0d/%0d/%0d le=%0d want %0d/%0d/%0d le=%0d", j,
                         obs_r1[j], obs_r2[j], obs_r3[j], obs_le[j], j, 1024 + j, 2048 + j, j);
            end
        end
        n_cmp++;
        if (shift_q.size() !== 1 || (shift_q.size() > 0 && shift_q[0] !== 21)) begin
            n_bad++; $display("FAIL single_shift: got %0d pulses first=%0d want 1 at 21",
                              shift_q.size(), shift_q.size() > 0 ? shift_q[0] : -1);
        end
        n_cmp++;
        if (done_cy !== 22 || done_cnt !== 1 || busy_post !== 1'b0) begin
            n_bad++; $display("FAIL single_done: got cy=%0d cnt=%0d busy_after=%b want 22/1/0",
                              done_cy, done_cnt, busy_post);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        @(posedge clk); #1;
        base_addr = 20'd0; row_idx = 20'd0; num_cols = 11'd4; start = 1'b1;
        for (int cy = 1; cy <= 12; cy++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_cmp++;
        if (row_1 !== 16'd1 || LE_select !== 2'd1) begin
            n_bad++; $display("FAIL midreset_pre: got row_1=%0d le=%0d want 1/1", row_1, LE_select);
        end
        arst_n_in = 1'b0;
        #1;
        n_cmp++;
        if ({mif.mem_re, mif.mem_addr, row_1, row_2, row_3, LE_select, shift, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got re=%b addr=%h r=%h/%h/%h le=%0d sh=%b busy=%b done=%b, want all 0",
                     mif.mem_re, mif.mem_addr, row_1, row_2, row_3, LE_select, shift, busy, done);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        arst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0) begin
            n_bad++; $display("FAIL midreset_idle: got %0d busy/done cycles want 0", done_seen);
        end
        run_band(20'd0, 20'd0, 11'd4, -1, -1, -1, -1, -1);
        n_cmp++;
        if (addr_q.size() !== 12 || (addr_q.size() > 0 && addr_q[0] !== 20'd0)) begin
            n_bad++; $display("FAIL midreset_replay_addr: got n=%0d first=%h want 12/0",
                              addr_q.size(), addr_q.size() > 0 ? addr_q[0] : 20'hfffff);
        end
        n_cmp++;
        if ({obs_r1[0], obs_r2[0], obs_r3[0], obs_le[0]} !== {16'd0, 16'd1024, 16'd2048, 2'd0} ||
            {obs_r1[3], obs_r2[3], obs_r3[3], obs_le[3]} !== {16'd3, 16'd1027, 16'd2051, 2'd3}) begin
            n_bad++; $display("FAIL midreset_replay_rows: got col0 %0d/%0d/%0d col3 %0d/%0d/%0d want 0/1024/2048 3/1027/2051",
                              obs_r1[0], obs_r2[0], obs_r3[0], obs_r1[3], obs_r2[3], obs_r3[3]);
        end
        n_cmp++;
        if (done_cy !== 22) begin
            n_bad++; $display("FAIL midreset_replay_done: got %0d want 22", done_cy);
        end
    endtask

    task automatic test_partial_group();
        logic [19:0] ga;
        run_band(20'd0, 20'd5, 11'd6, -1, -1, -1, -1, -1);
        n_cmp++;
        if (addr_q.size() !== 18) begin
            n_bad++; $display("FAIL partial_nreads: got %0d want 18", addr_q.size());
        end
        ga = (addr_q.size() > 0) ? addr_q[0] : 20'hxxxxx;
        n_cmp++;
        if (ga !== 20'd5120) begin
            n_bad++; $display("FAIL partial_first_addr: got %0d want 5120", ga);
        end
        ga = (addr_q.size() > 17) ? addr_q[17] : 20'hxxxxx;
        n_cmp++;
        if (ga !== 20'd7173) begin
            n_bad++; $display("FAIL partial_last_addr: got %0d want 7173", ga);
        end
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if ({obs_r1[j], obs_r2[j], obs_r3[j], obs_le[j]} !==
                {16'(5120 + j), 16'(6144 + j), 16'(7168 + j), 2'(j % 4)}) begin
                n_bad++;
                $display("FAIL partial_load col%0d: got %0d/%0d/%0d le=%0d want %0d/%0d/%0d le=%0d", j,
                         obs_r1[j], obs_r2[j], obs_r3[j], obs_le[j], 5120 + j, 6144 + j, 7168 + j, j % 4);
            end
        end
        n_cmp++;
        if (shift_q.size() !== 2 || (shift_q.size() == 2 && (shift_q[0] !== 21 || shift_q[1] !== 32))) begin
            n_bad++; $display("FAIL partial_shift: got %0d pulses want 2 at 21,32", shift_q.size());
        end
        n_cmp++;
        if (done_cy !== 33 || done_cnt !== 1) begin
            n_bad++; $display("FAIL partial_done: got cy=%0d cnt=%0d want 33/1", done_cy, done_cnt);
        end
    endtask

    task automatic test_stall();
        logic [19:0] ga;
        int          bad_addr = 0;
        // Stall RD k=1 of column 0 for 7 cycles, then the SHIFT state for 3 cycles.
        run_band(20'd0, 20'd0, 11'd4, 2, 8, 28, 30, -1);
        n_cmp++;
        if (re_in_stall !== 0) begin
            n_bad++; $display("FAIL stall_re_low: got %0d reads while stalled want 0", re_in_stall);
        end
        for (int i = 0; i < 12; i++) begin
            ga = (i < addr_q.size()) ? addr_q[i] : 20'hxxxxx;
            if (ga !== 20'((i / 3) + (i % 3) * 1024)) bad_addr++;
        end
        n_cmp++;
        if (addr_q.size() !== 12 || bad_addr !== 0) begin
            n_bad++; $display("FAIL stall_addr_seq: got n=%0d bad=%0d want 12/0", addr_q.size(), bad_addr);
        end
        n_cmp++;
        if ({obs_r1[1], obs_r2[1], obs_r3[1], obs_le[1]} !== {16'd1, 16'd1025, 16'd2049, 2'd1}) begin
            n_bad++; $display("FAIL stall_rows: got %0d/%0d/%0d le=%0d want 1/1025/2049 le=1",
                              obs_r1[1], obs_r2[1], obs_r3[1], obs_le[1]);
        end
        n_cmp++;
        if (shift_q.size() !== 1 || (shift_q.size() > 0 && shift_q[0] !== 31)) begin
            n_bad++; $display("FAIL stall_shift: got %0d pulses first=%0d want 1 at 31",
                              shift_q.size(), shift_q.size() > 0 ? shift_q[0] : -1);
        end
        n_cmp++;
        if (done_cy !== 32) begin
            n_bad++; $display("FAIL stall_done: got %0d want 32", done_cy);
        end
    endtask

    task automatic test_edge_cases();
        logic [19:0] ga;
        run_band(20'd77, 20'd3, 11'd0, -1, -1, -1, -1, -1);
        n_cmp++;
        if (done_cy !== 1 || addr_q.size() !== 0 || shift_q.size() !== 0 || busy_post !== 1'b0) begin
            n_bad++; $display("FAIL zero_cols: got done=%0d reads=%0d shifts=%0d busy_after=%b want 1/0/0/0",
                              done_cy, addr_q.size(), shift_q.size(), busy_post);
        end
        // A second start (num_cols=0, other base) in cycle 4 must not disturb the band.
        run_band(20'd0, 20'd0, 11'd2, -1, -1, -1, -1, 4);
        n_cmp++;
        if (addr_q.size() !== 6 || done_cy !== 12 || done_cnt !== 1) begin
            n_bad++; $display("FAIL start_busy: got reads=%0d done=%0d cnt=%0d want 6/12/1",
                              addr_q.size(), done_cy, done_cnt);
        end
        ga = (addr_q.size() > 5) ? addr_q[5] : 20'hxxxxx;
        n_cmp++;
        if (ga !== 20'd2049) begin
            n_bad++; $display("FAIL start_busy_addr: got %0d want 2049", ga);
        end
        run_band(20'hFFFFF, 20'd0, 11'd1, -1, -1, -1, -1, -1);
        ga = (addr_q.size() > 1) ? addr_q[1] : 20'hxxxxx;
        n_cmp++;
        if (ga !== 20'd1023) begin
            n_bad++; $display("FAIL wrap_addr: got %0d want 1023", ga);
        end
        n_cmp++;
        if ({obs_r1[0], obs_r2[0], obs_r3[0]} !== {16'hFFFF, 16'd1023, 16'd2047} ||
            shift_q.size() !== 1 || done_cy !== 7) begin
            n_bad++; $display("FAIL wrap_rows: got %h/%0d/%0d shifts=%0d done=%0d want ffff/1023/2047 1 7",
                              obs_r1[0], obs_r2[0], obs_r3[0], shift_q.size(), done_cy);
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_reset_mid();
        test_partial_group();
        test_stall();
        test_edge_cases();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
